// File: rtl/nanorv32_retire_trace_buf.sv
// rtl/nanorv32_retire_trace_buf.sv - retire-trace capture FIFO for the nanorv32 core
//
// Captures one entry per retired instruction: PC, instruction word and the rd writeback.
// A retiring load waits in a pending register until its data phase completes. It is then
// pushed together with the loaded value. Entries go into a circular FIFO that is drained
// through a valid/ready pop port.
//
// Optional feature: define NANORV32_TRACE_TIMESTAMP_EN to add a free-running cycle counter.
// Each entry then carries the counter value of its retire cycle on out_tstamp.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   trace_en, trace_clr  capture enable, synchronous clear
//   ret_*                retire-stage inputs (valid, pc, instr, is_load, rd_we/idx/data)
//   ld_*                 outstanding-load completion (done, rd_we, rd_data)
//   out_valid/out_ready  pop handshake; out_pc/instr/rd_we/rd_idx/rd_data give the head entry
//   overflow, drop_cnt   sticky drop flag and saturating drop counter
//   level                current occupancy (the extra bit tells full from empty)
//   out_tstamp           head timestamp (NANORV32_TRACE_TIMESTAMP_EN only)

module nanorv32_retire_trace_buf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trace_en,
    input  logic                  trace_clr,
    input  logic                  ret_valid,
    input  logic [31:0]           ret_pc,
    input  logic [31:0]           ret_instr,
    input  logic                  ret_is_load,
    input  logic                  ret_rd_we,
    input  logic [4:0]            ret_rd_idx,
    input  logic [31:0]           ret_rd_data,
    input  logic                  ld_done,
    input  logic                  ld_rd_we,
    input  logic [31:0]           ld_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_instr,
    output logic                  out_rd_we,
    output logic [4:0]            out_rd_idx,
    output logic [31:0]           out_rd_data,
`ifdef NANORV32_TRACE_TIMESTAMP_EN
    output logic [31:0]           out_tstamp,
`endif
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_we;
        logic [4:0]  rd_idx;
        logic [31:0] rd_data;
`ifdef NANORV32_TRACE_TIMESTAMP_EN
        logic [31:0] tstamp;
`endif
    } entry_t;

    entry_t                  r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [LW-1:0]           r_level;
    logic                    r_overflow;
    logic [DROP_CNT_W-1:0]   r_drop_cnt;

    logic                    r_pend_valid;
    logic [31:0]             r_pend_pc;
    logic [31:0]             r_pend_instr;
    logic [4:0]              r_pend_idx;
`ifdef NANORV32_TRACE_TIMESTAMP_EN
    logic [31:0]             r_cycle;
    logic [31:0]             r_pend_ts;
`endif

    logic                    w_pop;
    logic                    w_new_load;
    logic                    w_push_a;
    logic                    w_push_b;
    logic [LW:0]             w_free;
    logic [LW:0]             w_free_b;
    logic                    w_a_ok;
    logic                    w_b_ok;
    logic [1:0]              w_drops;
    logic [DROP_CNT_W:0]     w_drop_sum;
    logic [DEPTH_LOG2-1:0]   w_addr_b;
    entry_t                  w_entry_a;
    entry_t                  w_entry_b;
    entry_t                  w_head;

    always_comb begin
        w_pop      = (r_level != '0) && out_ready;
        w_new_load = ret_valid && ret_is_load && trace_en;
        // The pending load leaves either on completion or when a new load overwrites it
        // (protocol error). In the overwrite case the old load has no data yet.
        w_push_a   = r_pend_valid && (ld_done || w_new_load);
        w_push_b   = ret_valid && !ret_is_load && trace_en;

        // Space freed by this cycle's pop counts. A is served before B.
        w_free     = (LW+1)'(DEPTH) - {1'b0, r_level} + (LW+1)'(w_pop);
        w_a_ok     = w_push_a && (w_free != '0);
        w_free_b   = w_free - (LW+1)'(w_a_ok);
        w_b_ok     = w_push_b && (w_free_b != '0);
        w_drops    = 2'(w_push_a && !w_a_ok) + 2'(w_push_b && !w_b_ok);
        w_drop_sum = {1'b0, r_drop_cnt} + (DROP_CNT_W+1)'(w_drops);
        w_addr_b   = r_wr_ptr + DEPTH_LOG2'(w_a_ok);

        w_entry_a         = '0;
        w_entry_a.pc      = r_pend_pc;
        w_entry_a.instr   = r_pend_instr;
        w_entry_a.rd_we   = ld_done && ld_rd_we;
        w_entry_a.rd_idx  = r_pend_idx;
        w_entry_a.rd_data = ld_done ? ld_rd_data : 32'h0;

        w_entry_b         = '0;
        w_entry_b.pc      = ret_pc;
        w_entry_b.instr   = ret_instr;
        w_entry_b.rd_we   = ret_rd_we;
        w_entry_b.rd_idx  = ret_rd_idx;
        w_entry_b.rd_data = ret_rd_data;
`ifdef NANORV32_TRACE_TIMESTAMP_EN
        w_entry_a.tstamp  = r_pend_ts;
        w_entry_b.tstamp  = r_cycle;
`endif
    end

    // Storage has no reset. The outputs are masked with out_valid, so stale content is never visible.
    always_ff @(posedge clk) begin
        if (w_a_ok) begin
            r_mem[r_wr_ptr] <= w_entry_a;
        end
        if (w_b_ok) begin
            r_mem[w_addr_b] <= w_entry_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
            r_pend_instr <= '0;
            r_pend_idx   <= '0;
`ifdef NANORV32_TRACE_TIMESTAMP_EN
            r_pend_ts    <= '0;
`endif
        end else if (trace_clr) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(w_a_ok) + DEPTH_LOG2'(w_b_ok);
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(w_pop);
            r_level  <= r_level + LW'(w_a_ok) + LW'(w_b_ok) - LW'(w_pop);
            if (w_drops != 2'd0) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
            end
            // Completion and push of the old pending load happen first. A load retiring
            // in the same cycle then takes over the pending register.
            if (w_new_load) begin
                r_pend_valid <= 1'b1;
                r_pend_pc    <= ret_pc;
                r_pend_instr <= ret_instr;
                r_pend_idx   <= ret_rd_idx;
`ifdef NANORV32_TRACE_TIMESTAMP_EN
                r_pend_ts    <= r_cycle;
`endif
            end else if (ld_done) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

`ifdef NANORV32_TRACE_TIMESTAMP_EN
    // Free-running; deliberately untouched by trace_clr so timestamps stay monotonic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`endif

    always_comb begin
        w_head      = r_mem[r_rd_ptr];
        out_valid   = (r_level != '0);
        out_pc      = out_valid ? w_head.pc      : 32'h0;
        out_instr   = out_valid ? w_head.instr   : 32'h0;
        out_rd_we   = out_valid && w_head.rd_we;
        out_rd_idx  = out_valid ? w_head.rd_idx  : 5'h0;
        out_rd_data = out_valid ? w_head.rd_data : 32'h0;
`ifdef NANORV32_TRACE_TIMESTAMP_EN
        out_tstamp  = out_valid ? w_head.tstamp  : 32'h0;
`endif
        overflow    = r_overflow;
        drop_cnt    = r_drop_cnt;
        level       = r_level;
    end

endmodule
